// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and helpers for the MIPS pipeline hazard controller:
// forward select codes, the "source unused" Tuse marker and mult/div latencies.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_E  = 2'b11;

  localparam logic [1:0] TUSE_NONE = 2'b11;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 4;

  // Register-writing view of one pipeline register (E, M or W).
  typedef struct packed {
    logic       regWrite;
    logic [4:0] a3;
    logic [1:0] tnew;
  } wr_stage_t;

  function automatic logic stageHit(input wr_stage_t st, input logic [4:0] src);
    return st.regWrite && (st.a3 == src) && (src != 5'd0);
  endfunction

  // Nearest matching stage wins; if it is not ready yet the select stays at
  // the register value and the stall logic holds the consumer instead.
  function automatic logic [1:0] pickFwd(input wr_stage_t  e,
                                         input logic       eAllowed,
                                         input wr_stage_t  m,
                                         input wr_stage_t  w,
                                         input logic [4:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (eAllowed && stageHit(e, src)) begin
      sel = (e.tnew == 2'd0) ? FWD_E : FWD_RF;
    end else if (stageHit(m, src)) begin
      sel = (m.tnew == 2'd0) ? FWD_M : FWD_RF;
    end else if (stageHit(w, src)) begin
      sel = (w.tnew == 2'd0) ? FWD_W : FWD_RF;
    end
    return sel;
  endfunction

  function automatic logic needStall(input wr_stage_t  st,
                                     input logic [4:0] src,
                                     input logic [1:0] tuse);
    return (tuse != TUSE_NONE) && stageHit(st, src) && (st.tnew > tuse);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Busy counter of the multi-cycle mult/div unit: loads the operation latency
// on a start and counts down to idle.
module md_busy_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_div,
  output logic o_busy
);

  logic [CNT_W-1:0] r_cnt;

  // A start while still busy simply reloads the latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: Tuse/Tnew stall detection, E>M>W forwarding
// selects and the mult/div busy interlock for the five-stage pipeline.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] i_rsD,
  input  logic [4:0] i_rtD,
  input  logic [1:0] i_TuseRsD,
  input  logic [1:0] i_TuseRtD,
  input  logic       i_mdD,
  input  logic [4:0] i_rsE,
  input  logic [4:0] i_rtE,
  input  logic [4:0] i_A3E,
  input  logic       i_RegWriteE,
  input  logic [1:0] i_TnewE,
  input  logic       i_startE,
  input  logic       i_divE,
  input  logic [4:0] i_rtM,
  input  logic [4:0] i_A3M,
  input  logic       i_RegWriteM,
  input  logic [1:0] i_TnewM,
  input  logic [4:0] i_A3W,
  input  logic       i_RegWriteW,
  input  logic [1:0] i_TnewW,
  output logic       o_stallF,
  output logic       o_stallD,
  output logic       o_flushE,
  output logic [1:0] o_fwdRsD,
  output logic [1:0] o_fwdRtD,
  output logic [1:0] o_fwdRsE,
  output logic [1:0] o_fwdRtE,
  output logic       o_fwdRtM,
  output logic       o_busy
);

  wr_stage_t w_stE, w_stM, w_stW;
  logic      w_dataStall, w_mdStall, w_stall, w_busy;

  assign w_stE = {i_RegWriteE, i_A3E, i_TnewE};
  assign w_stM = {i_RegWriteM, i_A3M, i_TnewM};
  assign w_stW = {i_RegWriteW, i_A3W, i_TnewW};

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .i_start(i_startE),
    .i_div  (i_divE),
    .o_busy (w_busy)
  );

  // Any producer still too far from ready blocks D, not only the nearest one.
  assign w_dataStall = needStall(w_stE, i_rsD, i_TuseRsD) ||
                       needStall(w_stM, i_rsD, i_TuseRsD) ||
                       needStall(w_stW, i_rsD, i_TuseRsD) ||
                       needStall(w_stE, i_rtD, i_TuseRtD) ||
                       needStall(w_stM, i_rtD, i_TuseRtD) ||
                       needStall(w_stW, i_rtD, i_TuseRtD);

  assign w_mdStall = i_mdD && (w_busy || i_startE);
  assign w_stall   = w_dataStall || w_mdStall;

  assign o_stallF = w_stall;
  assign o_stallD = w_stall;
  assign o_flushE = w_stall;

  assign o_fwdRsD = pickFwd(w_stE, 1'b1, w_stM, w_stW, i_rsD);
  assign o_fwdRtD = pickFwd(w_stE, 1'b1, w_stM, w_stW, i_rtD);
  assign o_fwdRsE = pickFwd(w_stE, 1'b0, w_stM, w_stW, i_rsE);
  assign o_fwdRtE = pickFwd(w_stE, 1'b0, w_stM, w_stW, i_rtE);
  assign o_fwdRtM = stageHit(w_stW, i_rtM) && (w_stW.tnew == 2'd0);

  assign o_busy = w_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios followed by
// randomized traffic compared against a stage-array reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, A3E, rtM, A3M, A3W;
  logic [1:0] TuseRsD, TuseRtD, TnewE, TnewM, TnewW;
  logic       mdD, RegWriteE, startE, divE, RegWriteM, RegWriteW;
  logic       stallF, stallD, flushE, fwdRtM, busy;
  logic [1:0] fwdRsD, fwdRtD, fwdRsE, fwdRtE;

  int checkCount = 0;
  int failCount  = 0;
  int modelCnt   = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .i_rsD(rsD), .i_rtD(rtD), .i_TuseRsD(TuseRsD), .i_TuseRtD(TuseRtD), .i_mdD(mdD),
    .i_rsE(rsE), .i_rtE(rtE), .i_A3E(A3E), .i_RegWriteE(RegWriteE), .i_TnewE(TnewE),
    .i_startE(startE), .i_divE(divE),
    .i_rtM(rtM), .i_A3M(A3M), .i_RegWriteM(RegWriteM), .i_TnewM(TnewM),
    .i_A3W(A3W), .i_RegWriteW(RegWriteW), .i_TnewW(TnewW),
    .o_stallF(stallF), .o_stallD(stallD), .o_flushE(flushE),
    .o_fwdRsD(fwdRsD), .o_fwdRtD(fwdRtD), .o_fwdRsE(fwdRsE), .o_fwdRtE(fwdRtE),
    .o_fwdRtM(fwdRtM), .o_busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    {rsD, rtD, rsE, rtE, A3E, rtM, A3M, A3W} = '0;
    TuseRsD = TUSE_NONE; TuseRtD = TUSE_NONE;
    {TnewE, TnewM, TnewW} = '0;
    {mdD, RegWriteE, startE, divE, RegWriteM, RegWriteW} = '0;
  endtask

  // Stage list ordered nearest first: index 0 = E, 1 = M, 2 = W.
  function automatic logic [1:0] refFwd(input logic [4:0] src, input int first);
    logic       rw [3];
    logic [4:0] a3 [3];
    logic [1:0] tn [3];
    rw = '{RegWriteE, RegWriteM, RegWriteW};
    a3 = '{A3E, A3M, A3W};
    tn = '{TnewE, TnewM, TnewW};
    for (int s = first; s < 3; s++)
      if (rw[s] && a3[s] == src && src != 5'd0)
        return (tn[s] == 2'd0) ? 2'(3 - s) : 2'b00;
    return 2'b00;
  endfunction

  function automatic logic refDataStall(input logic [4:0] src, input logic [1:0] tuse);
    logic       rw [3];
    logic [4:0] a3 [3];
    int         tn [3];
    rw = '{RegWriteE, RegWriteM, RegWriteW};
    a3 = '{A3E, A3M, A3W};
    tn = '{int'(TnewE), int'(TnewM), int'(TnewW)};
    for (int s = 0; s < 3; s++)
      if (rw[s] && a3[s] == src && src != 5'd0 && tn[s] > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkAll(input string tag);
    logic expStall;
    expStall = refDataStall(rsD, TuseRsD) || refDataStall(rtD, TuseRtD) ||
               (mdD && (modelCnt > 0 || startE));
    checkOutput({tag, "/stallF"}, 32'(stallF), 32'(expStall));
    checkOutput({tag, "/stallD"}, 32'(stallD), 32'(expStall));
    checkOutput({tag, "/flushE"}, 32'(flushE), 32'(expStall));
    checkOutput({tag, "/fwdRsD"}, 32'(fwdRsD), 32'(refFwd(rsD, 0)));
    checkOutput({tag, "/fwdRtD"}, 32'(fwdRtD), 32'(refFwd(rtD, 0)));
    checkOutput({tag, "/fwdRsE"}, 32'(fwdRsE), 32'(refFwd(rsE, 1)));
    checkOutput({tag, "/fwdRtE"}, 32'(fwdRtE), 32'(refFwd(rtE, 1)));
    checkOutput({tag, "/fwdRtM"}, 32'(fwdRtM), 32'(refFwd(rtM, 2) == 2'b01));
    checkOutput({tag, "/busy"},   32'(busy),   32'(modelCnt > 0));
  endtask

  task automatic applyStimulus();
    reset     = ($urandom_range(0, 49) == 0);
    rsD       = 5'($urandom_range(0, 3));
    rtD       = 5'($urandom_range(0, 3));
    rsE       = 5'($urandom_range(0, 3));
    rtE       = 5'($urandom_range(0, 3));
    rtM       = 5'($urandom_range(0, 3));
    A3E       = 5'($urandom_range(0, 3));
    A3M       = 5'($urandom_range(0, 3));
    A3W       = 5'($urandom_range(0, 3));
    TuseRsD   = 2'($urandom_range(0, 3));
    TuseRtD   = 2'($urandom_range(0, 3));
    TnewE     = 2'($urandom_range(0, 3));
    TnewM     = 2'($urandom_range(0, 2));
    TnewW     = 2'($urandom_range(0, 1));
    RegWriteE = 1'($urandom_range(0, 1));
    RegWriteM = 1'($urandom_range(0, 1));
    RegWriteW = 1'($urandom_range(0, 1));
    mdD       = ($urandom_range(0, 2) == 0);
    startE    = ($urandom_range(0, 7) == 0);
    divE      = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int stalls, busys;
    clearInputs();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset/busy",   32'(busy),   0);
    checkOutput("reset/stallF", 32'(stallF), 0);
    checkOutput("reset/fwdRsD", 32'(fwdRsD), 0);
    checkOutput("reset/fwdRtM", 32'(fwdRtM), 0);
    reset = 1'b0;

    // lw $1 in E, add using $1 in D
    clearInputs();
    RegWriteE = 1; A3E = 5'd1; TnewE = 2'd2; rsD = 5'd1; TuseRsD = 2'd1;
    #1 checkOutput("lwE/stall", 32'(stallF), 1);
    checkOutput("lwE/flushE", 32'(flushE), 1);
    @(negedge clk);
    clearInputs();
    RegWriteW = 1; A3W = 5'd1; TnewW = 2'd0; rsE = 5'd1;
    #1 checkOutput("lwW/fwdRsE", 32'(fwdRsE), 32'(FWD_W));
    checkOutput("lwW/stall", 32'(stallF), 0);

    // add $1 in M, beq $1 in D
    @(negedge clk);
    clearInputs();
    RegWriteM = 1; A3M = 5'd1; TnewM = 2'd0; rsD = 5'd1; TuseRsD = 2'd0;
    #1 checkOutput("beq/fwdRsD", 32'(fwdRsD), 32'(FWD_M));
    checkOutput("beq/stall", 32'(stallF), 0);

    // E and M both produce $5
    @(negedge clk);
    clearInputs();
    RegWriteE = 1; A3E = 5'd5; RegWriteM = 1; A3M = 5'd5; rsD = 5'd5; TuseRsD = 2'd0;
    #1 checkOutput("prio/fwdRsD", 32'(fwdRsD), 32'(FWD_E));

    // $0 everywhere
    @(negedge clk);
    clearInputs();
    RegWriteE = 1; RegWriteM = 1; RegWriteW = 1; TnewE = 2'd2; TuseRsD = 2'd0;
    #1 checkOutput("zero/fwdRsD", 32'(fwdRsD), 0);
    checkOutput("zero/fwdRsE", 32'(fwdRsE), 0);
    checkOutput("zero/fwdRtM", 32'(fwdRtM), 0);
    checkOutput("zero/stall",  32'(stallF), 0);

    // div in E with mflo waiting in D
    @(negedge clk);
    clearInputs();
    mdD = 1; startE = 1; divE = 1;
    stalls = 0; busys = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        startE = 0;
      end
      #1;
      if (cyc == 0) checkOutput("div/busyAtStart", 32'(busy), 0);
      if (cyc == 10) checkOutput("div/busyLast", 32'(busy), 1);
      if (cyc == 11) checkOutput("div/busyAfter", 32'(busy), 0);
      if (stallF) stalls++;
      if (busy) busys++;
    end
    checkOutput("div/stallCycles", 32'(stalls), 11);
    checkOutput("div/busyCycles",  32'(busys), 10);

    // reset in the middle of a mult count
    @(negedge clk);
    clearInputs();
    mdD = 1; startE = 1;
    @(negedge clk);
    startE = 0;
    @(negedge clk);
    #1 checkOutput("multRst/busyBefore", 32'(busy), 1);
    checkOutput("multRst/stallBefore", 32'(stallF), 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1 checkOutput("multRst/busyAfter", 32'(busy), 0);
    checkOutput("multRst/stallAfter", 32'(stallF), 0);

    // randomized traffic against the reference model
    @(negedge clk);
    clearInputs();
    reset = 1;
    @(negedge clk);
    reset = 0;
    modelCnt = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      applyStimulus();
      #1 checkAll($sformatf("rnd%0d", n));
      if (reset) modelCnt = 0;
      else if (startE) modelCnt = divE ? 10 : 5;
      else if (modelCnt > 0) modelCnt--;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
